err_metric_acc: RTL and testbench
=================================

ERR_METRIC_ACC -- requirements
Module: err_metric_acc

Interface
REQ-001 Parameter N_SAMPLES, default 10000, samples per measurement run (1..65535).
REQ-002 Parameter DW, default 8, multiplier operand width; product width PW = 2*DW.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; clears accumulators and begins a run.
REQ-006 sample_valid  input  1  dat_in_a/dat_in_b/apprx carry one sample.
REQ-007 sample_ready  output  1  block accepts a sample this cycle.
REQ-008 dat_in_a, dat_in_b  input  DW each  operands applied to the approximate multiplier.
REQ-009 apprx  input  PW  approximate product for those operands.
REQ-010 busy  output  1  run in progress (RUN or DRAIN).
REQ-011 done  output  1  level; metrics final and stable.
REQ-012 err_count  output  16  samples with apprx != exact.
REQ-013 sum_ed_abs  output  32  sum of |exact - apprx|.
REQ-014 max_ed  output  PW  largest |exact - apprx| in the run.
REQ-015 nz_count  output  16  samples with exact != 0, the MRED denominator base.

Function
REQ-016 FSM states IDLE, RUN, DRAIN, DONE; start in IDLE or DONE -> RUN, clearing all metric outputs and the accepted-sample counter that cycle.
REQ-017 start in RUN or DRAIN is ignored.
REQ-018 sample_ready = (state == RUN) and accepted count < N_SAMPLES; a sample transfers when sample_valid and sample_ready are both high.
REQ-019 Stage 1 (cycle after transfer): register exact = dat_in_a * dat_in_b, unsigned, full PW bits, and |exact - apprx| computed without overflow.
REQ-020 Stage 2 (following cycle): update err_count, sum_ed_abs, max_ed (strictly greater replaces), nz_count; metric latency = 2 cycles after transfer.
REQ-021 On the N_SAMPLES-th transfer, RUN -> DRAIN; DRAIN -> DONE once both pipeline stages are empty (exactly 2 cycles).
REQ-022 done = 1 only in DONE; busy = 1 only in RUN and DRAIN; metric outputs hold in DONE until the next start.
REQ-023 Gaps in sample_valid are legal; the pipeline advances only on valid transfers, and bubbles update nothing.
REQ-024 sum_ed_abs does not wrap: 65535 * 65025 < 2^32; err_count and nz_count never exceed N_SAMPLES.

Reset
REQ-025 rst_n low forces IDLE, sample_ready = 0, busy = 0, done = 0, all metrics 0, pipeline valids 0, regardless of clock.
REQ-026 Reset mid-run discards the run entirely; a new start is required after release.

Configuration
REQ-027 Macro ERR_METRIC_SIGNED_ED_EN, when defined, adds output sum_ed (signed, 33 bits) = sum of (exact - apprx), cleared and updated alongside sum_ed_abs.
REQ-028 Without ERR_METRIC_SIGNED_ED_EN, the port and its logic are absent; all other behaviour is identical.

Structure
REQ-029 Package approx_mult_pkg holds DW/PW defaults, metric width constants, and the FSM state enum.
REQ-030 Sub-module err_dist_calc (combinational plus one register stage) computes exact, |ed|, signed ed, mismatch flag and nonzero flag; the top holds the FSM, counter and accumulators.

Verification
REQ-031 N_SAMPLES=4; samples (3,5,15), (255,255,65024), (0,7,0), (16,16,262) -> done; err_count=2, sum_ed_abs=7, max_ed=6, nz_count=3; sum_ed=-5 with macro.
REQ-032 N_SAMPLES=1; sample (255,255,0) -> max_ed=65025, sum_ed_abs=65025, err_count=1.
REQ-033 sample_valid held high for 3 cycles after the 4th transfer -> sample_ready=0, those samples not counted, done exactly 2 cycles after the 4th transfer.
REQ-034 rst_n pulsed low after 2 of 4 samples -> all outputs 0 immediately, IDLE; a fresh start plus 4 samples gives the REQ-031 values.
REQ-035 Second start in DONE -> metrics cleared the same cycle, busy=1, done=0; start asserted in RUN -> no effect on counts.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// Shared widths and FSM encoding for the approximate-multiplier error metric block.
package approx_mult_pkg;

   localparam int DW_DEF = 8;
   localparam int PW_DEF = 2 * DW_DEF;
   localparam int CNT_W  = 16;
   localparam int SUM_W  = 32;
   localparam int SED_W  = 33;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/err_dist_calc.sv
// Exact product and error distance for one sample, registered once.
// ERR_METRIC_SIGNED_ED_EN adds the signed error distance output.
module err_dist_calc
   import approx_mult_pkg::*;
#(
   parameter int DW = DW_DEF,
   localparam int PW = 2 * DW
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [PW-1:0] apprx,
   output logic          out_valid,
   output logic [PW-1:0] exact,
   output logic [PW-1:0] ed_abs,
`ifdef ERR_METRIC_SIGNED_ED_EN
   output logic signed [PW:0] ed,
`endif
   output logic          mismatch,
   output logic          nonzero
);

   logic [PW-1:0] prod;
   logic [PW-1:0] mag;

   assign prod = PW'(a) * PW'(b);
   // Subtract in the order that cannot underflow.
   assign mag  = (prod >= apprx) ? (prod - apprx) : (apprx - prod);

`ifdef ERR_METRIC_SIGNED_ED_EN
   logic signed [PW:0] diff;
   assign diff = $signed({1'b0, prod}) - $signed({1'b0, apprx});
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         exact     <= '0;
         ed_abs    <= '0;
         mismatch  <= 1'b0;
         nonzero   <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            exact    <= prod;
            ed_abs   <= mag;
            mismatch <= (prod != apprx);
            nonzero  <= (prod != '0);
         end
      end
   end

`ifdef ERR_METRIC_SIGNED_ED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ed <= '0;
      end else if (in_valid) begin
         ed <= diff;
      end
   end
`endif

endmodule

// File: rtl/err_metric_acc.sv
// Run controller and error metric accumulators for an approximate multiplier.
// ERR_METRIC_SIGNED_ED_EN adds the signed error sum output sum_ed.
module err_metric_acc
   import approx_mult_pkg::*;
#(
   parameter int N_SAMPLES = 10000,
   parameter int DW = DW_DEF,
   localparam int PW = 2 * DW
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          sample_valid,
   output logic          sample_ready,
   input  logic [DW-1:0] dat_in_a,
   input  logic [DW-1:0] dat_in_b,
   input  logic [PW-1:0] apprx,
   output logic          busy,
   output logic          done,
   output logic [15:0]   err_count,
   output logic [31:0]   sum_ed_abs,
   output logic [PW-1:0] max_ed,
`ifdef ERR_METRIC_SIGNED_ED_EN
   output logic signed [32:0] sum_ed,
`endif
   output logic [15:0]   nz_count
);

   localparam logic [CNT_W-1:0] N_LIM = CNT_W'(N_SAMPLES);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] acc_cnt;
   logic             xfer;
   logic             last_xfer;
   logic             clr;

   logic             s1_valid;
   logic [PW-1:0]    s1_exact;
   logic [PW-1:0]    s1_ed_abs;
   logic             s1_mismatch;
   logic             s1_nonzero;
`ifdef ERR_METRIC_SIGNED_ED_EN
   logic signed [PW:0] s1_ed;
`endif

   assign xfer      = sample_valid & sample_ready;
   assign last_xfer = xfer & (acc_cnt == N_LIM - 1'b1);

   always_comb begin
      state_nxt    = state;
      sample_ready = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      clr          = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               clr       = 1'b1;
            end
         end
         RUN: begin
            busy         = 1'b1;
            sample_ready = (acc_cnt < N_LIM);
            if (last_xfer) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy      = 1'b1;
            // The final sample retires from stage 1 into the sums on this edge.
            state_nxt = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               state_nxt = RUN;
               clr       = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_cnt <= '0;
      end else if (clr) begin
         acc_cnt <= '0;
      end else if (xfer) begin
         acc_cnt <= acc_cnt + 1'b1;
      end
   end

   err_dist_calc #(
      .DW(DW)
   ) u_calc (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (xfer),
      .a        (dat_in_a),
      .b        (dat_in_b),
      .apprx    (apprx),
      .out_valid(s1_valid),
      .exact    (s1_exact),
      .ed_abs   (s1_ed_abs),
`ifdef ERR_METRIC_SIGNED_ED_EN
      .ed       (s1_ed),
`endif
      .mismatch (s1_mismatch),
      .nonzero  (s1_nonzero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count  <= '0;
         sum_ed_abs <= '0;
         max_ed     <= '0;
         nz_count   <= '0;
      end else if (clr) begin
         err_count  <= '0;
         sum_ed_abs <= '0;
         max_ed     <= '0;
         nz_count   <= '0;
      end else if (s1_valid) begin
         if (s1_mismatch) err_count <= err_count + 1'b1;
         if (s1_nonzero)  nz_count  <= nz_count + 1'b1;
         sum_ed_abs <= sum_ed_abs + SUM_W'(s1_ed_abs);
         if (s1_ed_abs > max_ed) max_ed <= s1_ed_abs;
      end
   end

`ifdef ERR_METRIC_SIGNED_ED_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_ed <= '0;
      end else if (clr) begin
         sum_ed <= '0;
      end else if (s1_valid) begin
         sum_ed <= sum_ed + SED_W'(s1_ed);
      end
   end
`endif

   logic unused_exact;
   assign unused_exact = ^s1_exact;

endmodule

// File: tb/tb_err_metric_acc.sv
// Directed bench for err_metric_acc with a list-based reference model.
// Build with ERR_METRIC_SIGNED_ED_EN to also check sum_ed.
module tb_err_metric_acc;

   localparam int NS = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        st4, v4, r4, busy4, done4;
   logic [7:0]  a4, b4;
   logic [15:0] p4, ec4, nz4, mx4;
   logic [31:0] sa4;
   logic        st1, v1, r1, busy1, done1;
   logic [7:0]  a1, b1;
   logic [15:0] p1, ec1, nz1, mx1;
   logic [31:0] sa1;
`ifdef ERR_METRIC_SIGNED_ED_EN
   logic signed [32:0] se4, se1;
`endif

   err_metric_acc #(.N_SAMPLES(NS), .DW(8)) u4 (
      .clk(clk), .rst_n(rst_n), .start(st4),
      .sample_valid(v4), .sample_ready(r4),
      .dat_in_a(a4), .dat_in_b(b4), .apprx(p4),
      .busy(busy4), .done(done4),
      .err_count(ec4), .sum_ed_abs(sa4), .max_ed(mx4),
`ifdef ERR_METRIC_SIGNED_ED_EN
      .sum_ed(se4),
`endif
      .nz_count(nz4)
   );

   err_metric_acc #(.N_SAMPLES(1), .DW(8)) u1 (
      .clk(clk), .rst_n(rst_n), .start(st1),
      .sample_valid(v1), .sample_ready(r1),
      .dat_in_a(a1), .dat_in_b(b1), .apprx(p1),
      .busy(busy1), .done(done1),
      .err_count(ec1), .sum_ed_abs(sa1), .max_ed(mx1),
`ifdef ERR_METRIC_SIGNED_ED_EN
      .sum_ed(se1),
`endif
      .nz_count(nz1)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: accepted samples with the edge index they transferred on.
   int  qa[$], qb[$], qp[$], qt[$];
   int  cyc = 0;
   int  m_last = 0;
   bit  m_started = 0;
   bit  m_rdy, m_bsy;
   bit  chk_on = 0;

   function automatic bit m_ready();
      return m_started && (qa.size() < NS);
   endfunction

   function automatic bit m_done();
      return m_started && (qa.size() == NS) && (cyc >= m_last + 1);
   endfunction

   function automatic bit m_busy();
      return m_started && !m_done();
   endfunction

   task automatic m_metrics(output longint ec, output longint sa,
                            output longint mx, output longint nz,
                            output longint se);
      longint ex, d, ad;
      ec = 0; sa = 0; mx = 0; nz = 0; se = 0;
      foreach (qa[i]) begin
         if (qt[i] <= cyc - 1) begin
            ex = longint'(qa[i]) * longint'(qb[i]);
            d  = ex - longint'(qp[i]);
            ad = (d < 0) ? -d : d;
            if (d != 0) ec++;
            if (ex != 0) nz++;
            sa += ad;
            se += d;
            if (ad > mx) mx = ad;
         end
      end
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         qa.delete(); qb.delete(); qp.delete(); qt.delete();
         m_started = 0;
         m_last = 0;
         cyc = 0;
      end else begin
         m_rdy = m_ready();
         m_bsy = m_busy();
         if (v4 && m_rdy) begin
            qa.push_back(int'(a4));
            qb.push_back(int'(b4));
            qp.push_back(int'(p4));
            qt.push_back(cyc + 1);
            m_last = cyc + 1;
         end
         if (st4 && !m_bsy) begin
            qa.delete(); qb.delete(); qp.delete(); qt.delete();
            m_started = 1;
         end
         cyc++;
      end
   end

   initial forever begin
      longint ec, sa, mx, nz, se;
      @(negedge clk);
      if (chk_on) begin
         m_metrics(ec, sa, mx, nz, se);
         chk("ready", r4, m_ready());
         chk("busy", busy4, m_busy());
         chk("done", done4, m_done());
         chk("err_count", ec4, ec);
         chk("sum_ed_abs", sa4, sa);
         chk("max_ed", mx4, mx);
         chk("nz_count", nz4, nz);
`ifdef ERR_METRIC_SIGNED_ED_EN
         chk("sum_ed", se4, se);
`endif
      end
   end

   task automatic start4();
      st4 = 1'b1;
      @(posedge clk); #1;
      st4 = 1'b0;
   endtask

   task automatic send4(input int a, input int b, input int p, input bit keep);
      bit ok;
      ok = 0;
      a4 = 8'(a); b4 = 8'(b); p4 = 16'(p); v4 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (r4) begin
            ok = 1;
            break;
         end
      end
      chk("send4_accepted", ok, 1);
      @(posedge clk); #1;
      if (!keep) v4 = 1'b0;
   endtask

   task automatic wait_done4();
      bit ok;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done4) begin
            ok = 1;
            break;
         end
      end
      chk("done4_timeout", ok, 1);
   endtask

   task automatic lit4(input string tag);
      chk({tag, "_err_count"}, ec4, 2);
      chk({tag, "_sum_ed_abs"}, sa4, 7);
      chk({tag, "_max_ed"}, mx4, 6);
      chk({tag, "_nz_count"}, nz4, 3);
`ifdef ERR_METRIC_SIGNED_ED_EN
      chk({tag, "_sum_ed"}, se4, -5);
`endif
   endtask

   initial begin
      bit ok;
      st4 = 0; v4 = 0; a4 = 0; b4 = 0; p4 = 0;
      st1 = 0; v1 = 0; a1 = 0; b1 = 0; p1 = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy4, 0);
      chk("rst_done", done4, 0);
      chk("rst_ready", r4, 0);
      chk("rst_sum", sa4, 0);
      chk_on = 1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      start4();
      chk("start_busy", busy4, 1);
      send4(3, 5, 15, 0);
      @(posedge clk); #1;
      send4(255, 255, 65024, 0);
      send4(0, 7, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      send4(16, 16, 262, 1);
      @(negedge clk);
      chk("drain_done", done4, 0);
      chk("drain_ready", r4, 0);
      @(negedge clk);
      chk("done_2cyc", done4, 1);
      @(posedge clk); #1;
      v4 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      lit4("run1");
      chk("run1_done_hold", done4, 1);

      start4();
      chk("restart_busy", busy4, 1);
      chk("restart_done", done4, 0);
      chk("restart_err", ec4, 0);
      chk("restart_max", mx4, 0);
      send4(255, 255, 65024, 0);
      send4(16, 16, 262, 0);
      start4();
      @(posedge clk); #1;
      chk("mid_err_count", ec4, 2);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy4, 0);
      chk("arst_err", ec4, 0);
      chk("arst_sum", sa4, 0);
      chk("arst_max", mx4, 0);
      chk("arst_ready", r4, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("idle_busy", busy4, 0);
      start4();
      send4(3, 5, 15, 0);
      send4(255, 255, 65024, 0);
      send4(0, 7, 0, 0);
      send4(16, 16, 262, 0);
      wait_done4();
      lit4("run2");

      st1 = 1'b1;
      @(posedge clk); #1;
      st1 = 1'b0;
      a1 = 8'd255; b1 = 8'd255; p1 = 16'd0; v1 = 1'b1;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (r1) begin
            ok = 1;
            break;
         end
      end
      chk("send1_accepted", ok, 1);
      @(posedge clk); #1;
      v1 = 1'b0;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (done1) begin
            ok = 1;
            break;
         end
      end
      chk("done1_timeout", ok, 1);
      chk("n1_max_ed", mx1, 65025);
      chk("n1_sum_ed_abs", sa1, 65025);
      chk("n1_err_count", ec1, 1);
      chk("n1_nz_count", nz1, 1);
      chk("n1_busy", busy1, 0);
`ifdef ERR_METRIC_SIGNED_ED_EN
      chk("n1_sum_ed", se1, 65025);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
